// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result buffer: op codes, entry layout and a packing helper.
// An entry is {op, c, z, n, result}, nine bits, with result in the low nibble.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    localparam int RESULT_W = 4;
    localparam int OP_W     = 2;
    localparam int ENTRY_W  = 9;

    localparam int ENTRY_RES_LSB = 0;
    localparam int ENTRY_RES_MSB = 3;
    localparam int ENTRY_N_POS   = 4;
    localparam int ENTRY_Z_POS   = 5;
    localparam int ENTRY_C_POS   = 6;
    localparam int ENTRY_OP_LSB  = 7;
    localparam int ENTRY_OP_MSB  = 8;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [OP_W-1:0]     op,
        input logic                c,
        input logic                z,
        input logic                n,
        input logic [RESULT_W-1:0] res
    );
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[ENTRY_RES_MSB:ENTRY_RES_LSB] = res;
        e[ENTRY_N_POS]                 = n;
        e[ENTRY_Z_POS]                 = z;
        e[ENTRY_C_POS]                 = c;
        e[ENTRY_OP_MSB:ENTRY_OP_LSB]   = op;
        return e;
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flag generation for one ALU result: carry (arithmetic ops only), zero, negative.
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [RESULT_W-1:0] i_result,
    input  logic                i_carry,
    input  logic [OP_W-1:0]     i_op,
    output logic                o_c,
    output logic                o_z,
    output logic                o_n
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        o_c = 1'b0;
        case (i_op)
            OP_ADD, OP_SUB: o_c = i_carry;
            OP_AND, OP_OR:  o_c = 1'b0;
        endcase
    end

    assign o_z = (i_result == '0);
    assign o_n = i_result[RESULT_W-1];

endmodule

// File: rtl/alu_result_buffer.sv
// Register-array FIFO holding ALU results with their flags; ready/valid on both sides,
// outputs come from the head entry only, so there is no combinational input-to-output path.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [RESULT_W-1:0]     in_result,
    input  logic                    in_carry,
    input  logic [OP_W-1:0]         in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RESULT_W-1:0]     out_result,
    output logic [OP_W-1:0]         out_op,
    output logic                    out_c,
    output logic                    out_z,
    output logic                    out_n,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;

    logic               w_push;
    logic               w_pop;
    logic               w_c;
    logic               w_z;
    logic               w_n;
    logic [ENTRY_W-1:0] w_wr_entry;
    logic [ENTRY_W-1:0] w_head;

    alu_flag_gen u_flag_gen (
        .i_result (in_result),
        .i_carry  (in_carry),
        .i_op     (in_op),
        .o_c      (w_c),
        .o_z      (w_z),
        .o_n      (w_n)
    );

    assign w_wr_entry = pack_entry(in_op, w_c, w_z, w_n, in_result);

    // Handshake status depends on the registered level only.
    assign in_ready  = (r_level < FULL_LEVEL);
    assign out_valid = (r_level != '0);
    assign level     = r_level;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: storage has no reset; stale contents are masked below whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_comb begin
        w_head = '0;
        if (out_valid) begin
            w_head = r_mem[r_rd_ptr];
        end
    end

    assign out_result = w_head[ENTRY_RES_MSB:ENTRY_RES_LSB];
    assign out_n      = w_head[ENTRY_N_POS];
    assign out_z      = w_head[ENTRY_Z_POS];
    assign out_c      = w_head[ENTRY_C_POS];
    assign out_op     = w_head[ENTRY_OP_MSB:ENTRY_OP_LSB];

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomized bench for alu_result_buffer, checked against a queue-based model of the buffer.
module tb_alu_result_buffer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_result;
    logic       in_carry;
    logic [1:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic [1:0] out_op;
    logic       out_c;
    logic       out_z;
    logic       out_n;
    logic [2:0] level;

    int total = 0;
    int bad   = 0;

    // Model: queue of stored entries, head at index 0, each {op, c, z, n, result}.
    logic [8:0] q[$];

    logic [13:0] w_obs;
    assign w_obs = {out_valid, in_ready, level, out_op, out_c, out_z, out_n, out_result};

    always #5 clk = ~clk;

    alu_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_carry   (in_carry),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .out_c      (out_c),
        .out_z      (out_z),
        .out_n      (out_n),
        .level      (level)
    );

    function automatic logic [8:0] mk_entry(input logic [1:0] op, input logic carry,
                                            input logic [3:0] res);
        logic c;
        c = (op == 2'b00 || op == 2'b01) ? carry : 1'b0;
        return {op, c, res == 4'd0, res[3], res};
    endfunction

    function automatic logic [13:0] model_obs();
        logic [8:0] head;
        logic [2:0] lvl;
        head = (q.size() != 0) ? q[0] : 9'd0;
        lvl  = 3'(q.size());
        return {q.size() != 0, q.size() < DEPTH, lvl, head};
    endfunction

    task automatic drive(input logic v, input logic [3:0] r, input logic c,
                         input logic [1:0] op, input logic ordy);
        in_valid  = v;
        in_result = r;
        in_carry  = c;
        in_op     = op;
        out_ready = ordy;
    endtask

    // Advance one clock edge, updating the model from the inputs presented before the edge.
    task automatic tick();
        bit         push;
        bit         pop;
        logic [8:0] e;
        push = in_valid && (q.size() < DEPTH);
        pop  = out_ready && (q.size() != 0);
        e    = mk_entry(in_op, in_carry, in_result);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 2'b00, 1'b0);
        #3;
        total++;
        if (w_obs !== 14'h1000) begin
            bad++;
            $display("FAIL reset_hold: got %h expected %h", w_obs, 14'h1000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (w_obs !== model_obs()) begin
                bad++;
                $display("FAIL reset_idle: got %h expected %h", w_obs, model_obs());
            end
        end
    endtask

    task automatic test_add_zero();
        drive(1'b1, 4'b0000, 1'b1, 2'b00, 1'b1);
        tick();
        drive(1'b0, 4'd0, 1'b0, 2'b00, 1'b1);
        total++;
        if ({out_valid, out_op, out_c, out_z, out_n, out_result} !== {1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 4'b0000}) begin
            bad++;
            $display("FAIL add_zero_flags: got %b expected %b",
                     {out_valid, out_op, out_c, out_z, out_n, out_result}, 10'b1_00_1_1_0_0000);
        end
        total++;
        if (w_obs !== model_obs()) begin
            bad++;
            $display("FAIL add_zero_model: got %h expected %h", w_obs, model_obs());
        end
        tick();
        total++;
        if ({out_valid, level} !== 4'b0_000) begin
            bad++;
            $display("FAIL add_zero_pop: got valid/level %b expected 0000", {out_valid, level});
        end
    endtask

    task automatic test_or_flags();
        drive(1'b1, 4'b1010, 1'b1, 2'b11, 1'b0);
        tick();
        drive(1'b0, 4'd0, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({out_valid, out_op, out_c, out_z, out_n, out_result} !== {1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 4'b1010}) begin
                bad++;
                $display("FAIL or_flags: got %b expected %b",
                         {out_valid, out_op, out_c, out_z, out_n, out_result}, 10'b1_11_0_0_1_1010);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (w_obs !== model_obs()) begin
            bad++;
            $display("FAIL or_drain: got %h expected %h", w_obs, model_obs());
        end
    endtask

    task automatic test_fill_drain();
        logic [3:0] got[$];
        bit         acc;
        int         cyc;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 4'(i), 1'b0, 2'b00, 1'b0);
            total++;
            if (in_ready !== (i <= DEPTH)) begin
                bad++;
                $display("FAIL fill_ready_%0d: got %b expected %b", i, in_ready, i <= DEPTH);
            end
            tick();
        end
        total++;
        if (level !== 3'd4) begin
            bad++;
            $display("FAIL fill_level: got %0d expected 4", level);
        end
        drive(1'b1, 4'd5, 1'b0, 2'b00, 1'b1);
        cyc = 0;
        while (got.size() < 5 && cyc < 20) begin
            total++;
            if (w_obs !== model_obs()) begin
                bad++;
                $display("FAIL drain_cycle_%0d: got %h expected %h", cyc, w_obs, model_obs());
            end
            if (out_valid) got.push_back(out_result);
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) in_valid = 1'b0;
        end
        total++;
        if (got.size() != 5) begin
            bad++;
            $display("FAIL drain_count: got %0d outputs expected 5", got.size());
        end
        for (int k = 0; k < got.size(); k++) begin
            total++;
            if (got[k] !== 4'(k + 1)) begin
                bad++;
                $display("FAIL drain_order_%0d: got %0d expected %0d", k, got[k], k + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'($urandom), 1'($urandom), 2'($urandom), 1'b0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'($urandom), 1'($urandom), 2'($urandom), 1'b1);
            total++;
            if (level !== 3'd2) begin
                bad++;
                $display("FAIL b2b_level_%0d: got %0d expected 2", i, level);
            end
            total++;
            if (w_obs !== model_obs()) begin
                bad++;
                $display("FAIL b2b_head_%0d: got %h expected %h", i, w_obs, model_obs());
            end
            tick();
        end
        drive(1'b0, 4'd0, 1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (w_obs !== model_obs()) begin
                bad++;
                $display("FAIL b2b_drain_%0d: got %h expected %h", i, w_obs, model_obs());
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] first;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'($urandom), 1'($urandom), 2'($urandom), 1'b0);
            tick();
        end
        total++;
        if (level !== 3'd3) begin
            bad++;
            $display("FAIL rmid_level: got %0d expected 3", level);
        end
        drive(1'b0, 4'd0, 1'b0, 2'b00, 1'b1);
        rst_n = 1'b0;
        #1;
        total++;
        if (w_obs !== 14'h1000) begin
            bad++;
            $display("FAIL rmid_async: got %h expected %h", w_obs, 14'h1000);
        end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (w_obs !== model_obs()) begin
            bad++;
            $display("FAIL rmid_idle: got %h expected %h", w_obs, model_obs());
        end
        first = 4'($urandom);
        drive(1'b1, first, 1'b0, 2'b10, 1'b0);
        tick();
        drive(1'b0, 4'd0, 1'b0, 2'b00, 1'b0);
        total++;
        if ({out_valid, out_result} !== {1'b1, first}) begin
            bad++;
            $display("FAIL rmid_first: got %b expected %b", {out_valid, out_result}, {1'b1, first});
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int pv;
            int pr;
            pv = (i < 200) ? 75 : 35;
            pr = (i < 200) ? 35 : 75;
            drive($urandom_range(0, 99) < pv, 4'($urandom), 1'($urandom), 2'($urandom),
                  $urandom_range(0, 99) < pr);
            total++;
            if (w_obs !== model_obs()) begin
                bad++;
                $display("FAIL random_%0d: got %h expected %h", i, w_obs, model_obs());
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_zero();
        test_or_flags();
        test_fill_drain();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
